rift_chip: RTL and testbench

RIFT_CHIP -- requirements
Module: rift_chip

---
 rtl/rift_chip.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_rift_chip.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rift_chip.sv
// rift_chip: multi-cycle RV64I core with a single-port 128 KiB SRAM.
// One instruction at a time through FETCH -> EXEC -> (MEM) -> WB; faults,
// ECALL and EBREAK park the core in HALT until reset.

// Storage array: one registered read port, byte-masked synchronous write.
module rift_sram (
  input  logic        CLK,
  input  logic        en,
  input  logic        we,
  input  logic [13:0] addr,
  input  logic [7:0]  wmask,
  input  logic [63:0] wdata,
  output logic [63:0] rdata
);
  logic [63:0] ram [16384];

  // Byte-masked write and registered read of the addressed word.
  // NOTE: the array has no reset; contents must survive reset so a preloaded image stays intact.
  always_ff @(posedge CLK) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 8; i++) begin
          if (wmask[i]) ram[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
      rdata <= ram[addr];
    end
  end
endmodule

// Window decode around the SRAM: accesses outside 0x8000_0000..+128 KiB
// read as zero and never write.
module rift_sram_port (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        en,
  input  logic        we,
  input  logic [60:0] waddr,   // 64-bit word address (byte address >> 3)
  input  logic [7:0]  wmask,
  input  logic [63:0] wdata,
  output logic [63:0] rdata
);
  logic        hit;
  logic        hit_q;
  logic [63:0] ram_rdata;

  assign hit = (waddr[60:14] == 47'h4000);

  rift_sram i_sram (
    .CLK   (CLK),
    .en    (en & hit),
    .we    (we & hit),
    .addr  (waddr[13:0]),
    .wmask (wmask),
    .wdata (wdata),
    .rdata (ram_rdata)
  );

  // Remember whether the outstanding read hit the window.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)   hit_q <= 1'b0;
    else if (en) hit_q <= hit;
  end

  assign rdata = hit_q ? ram_rdata : 64'd0;
endmodule

module rift_chip (
  input logic CLK,
  input logic RSTn
);
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_EXEC = 3'd1, S_MEM = 3'd2, S_WB = 3'd3, S_HALT = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [63:0] pc, cycle;
  logic [63:0] regfile [32];

  // EXEC results carried into MEM/WB
  logic [4:0]  rd_q;
  logic        wr_q, ld_q, st_q;
  logic [2:0]  f3_q;
  logic [63:0] res_q, npc_q, addr_q, sdata_q;

  // memory port
  logic        mem_en, mem_we;
  logic [60:0] mem_waddr;
  logic [7:0]  mem_wmask;
  logic [63:0] mem_wdata, mem_rdata;

  rift_sram_port i_axi_full_slv_sram (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .en    (mem_en),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wmask (mem_wmask),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  function automatic logic [63:0] alu(input logic [63:0] x, input logic [63:0] y,
                                      input logic [2:0] op, input logic alt, input logic word);
    logic [63:0] r, xs, xz;
    logic [5:0]  sh;
    sh = word ? {1'b0, y[4:0]} : y[5:0];
    xs = word ? {{32{x[31]}}, x[31:0]} : x;
    xz = word ? {32'd0, x[31:0]} : x;
    case (op)
      3'd0: r = alt ? x - y : x + y;
      3'd1: r = x << sh;
      3'd2: r = {63'd0, $signed(x) < $signed(y)};
      3'd3: r = {63'd0, x < y};
      3'd4: r = x ^ y;
      3'd5: if (alt) r = $signed(xs) >>> sh; else r = xz >> sh;
      3'd6: r = x | y;
      default: r = x & y;
    endcase
    return word ? {{32{r[31]}}, r[31:0]} : r;
  endfunction

  // decode / execute signals
  logic [31:0] instr;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [63:0] a, b, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic        ex_wr, ex_ld, ex_st, ex_fault, ex_stop, taken, sh_bad, r_bad, f3_w_ok;
  logic [63:0] ex_res, ex_npc, ex_addr;

  // Decode the fetched word, compute result, next PC and effective address.
  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    instr   = pc[2] ? mem_rdata[63:32] : mem_rdata[31:0];
    opc     = instr[6:0];
    rd      = instr[11:7];
    f3      = instr[14:12];
    rs1     = instr[19:15];
    rs2     = instr[24:20];
    f7      = instr[31:25];
    a       = regfile[rs1];
    b       = regfile[rs2];
    imm_i   = {{52{instr[31]}}, instr[31:20]};
    imm_s   = {{52{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b   = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u   = {{32{instr[31]}}, instr[31:12], 12'd0};
    imm_j   = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    sh_bad  = (f3 == 3'd1 && instr[31:26] != 6'd0) ||
              (f3 == 3'd5 && (instr[31] || instr[29:26] != 4'd0));
    r_bad   = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
    f3_w_ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5);
    ex_wr    = 1'b0;
    ex_ld    = 1'b0;
    ex_st    = 1'b0;
    ex_fault = 1'b0;
    ex_stop  = 1'b0;
    ex_res   = 64'd0;
    ex_npc   = pc + 64'd4;
    ex_addr  = a + imm_i;
    case (f3)
      3'd0:    taken = (a == b);
      3'd1:    taken = (a != b);
      3'd4:    taken = ($signed(a) <  $signed(b));
      3'd5:    taken = ($signed(a) >= $signed(b));
      3'd6:    taken = (a <  b);
      3'd7:    taken = (a >= b);
      default: taken = 1'b0;
    endcase
    case (opc)
      7'h37: begin ex_wr = 1'b1; ex_res = imm_u; end
      7'h17: begin ex_wr = 1'b1; ex_res = pc + imm_u; end
      7'h6F: begin ex_wr = 1'b1; ex_res = pc + 64'd4; ex_npc = pc + imm_j; end
      7'h67: begin
        ex_wr = 1'b1; ex_res = pc + 64'd4;
        ex_npc = (a + imm_i) & ~64'd1;
        ex_fault = (f3 != 3'd0);
      end
      7'h63: begin
        if (taken) ex_npc = pc + imm_b;
        ex_fault = (f3 == 3'd2 || f3 == 3'd3);
      end
      7'h03: begin ex_ld = 1'b1; ex_wr = 1'b1; ex_fault = (f3 == 3'd7); end
      7'h23: begin ex_st = 1'b1; ex_addr = a + imm_s; ex_fault = f3[2]; end
      7'h13: begin
        ex_wr = 1'b1; ex_res = alu(a, imm_i, f3, f3 == 3'd5 && instr[30], 1'b0);
        ex_fault = sh_bad;
      end
      7'h1B: begin
        ex_wr = 1'b1; ex_res = alu(a, imm_i, f3, f3 == 3'd5 && instr[30], 1'b1);
        ex_fault = sh_bad || !f3_w_ok || (f3 != 3'd0 && instr[25]);
      end
      7'h33: begin ex_wr = 1'b1; ex_res = alu(a, b, f3, instr[30], 1'b0); ex_fault = r_bad; end
      7'h3B: begin
        ex_wr = 1'b1; ex_res = alu(a, b, f3, instr[30], 1'b1);
        ex_fault = r_bad || !f3_w_ok;
      end
      7'h0F: ;  // FENCE / FENCE.I: nothing to order in a single-issue core
      7'h73: begin
        if (f3 == 3'd0)      ex_stop  = 1'b1;  // ECALL, EBREAK
        else if (f3 == 3'd4) ex_fault = 1'b1;
        else begin
          ex_wr  = 1'b1;
          ex_res = (f3[1:0] == 2'b10 && (instr[31:20] == 12'hC00 || instr[31:20] == 12'hB00))
                   ? cycle : 64'd0;
        end
      end
      default: ex_fault = 1'b1;
    endcase
    if (ex_npc[1:0] != 2'd0) ex_fault = 1'b1;
    if (ex_ld || ex_st) begin
      case (f3[1:0])
        2'd1:    if (ex_addr[0])         ex_fault = 1'b1;
        2'd2:    if (|ex_addr[1:0])      ex_fault = 1'b1;
        2'd3:    if (|ex_addr[2:0])      ex_fault = 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state selection and memory port control.
  always_comb begin
    state_nx  = state;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = pc[63:3];
    mem_wmask = 8'd0;
    mem_wdata = sdata_q << {addr_q[2:0], 3'b000};
    case (state)
      S_FETCH: begin mem_en = 1'b1; state_nx = S_EXEC; end
      S_EXEC: begin
        if (ex_fault || ex_stop)  state_nx = S_HALT;
        else if (ex_ld || ex_st)  state_nx = S_MEM;
        else                      state_nx = S_WB;
      end
      S_MEM: begin
        mem_en    = 1'b1;
        mem_we    = st_q;
        mem_waddr = addr_q[63:3];
        case (f3_q[1:0])
          2'd0:    mem_wmask = 8'h01 << addr_q[2:0];
          2'd1:    mem_wmask = 8'h03 << addr_q[2:0];
          2'd2:    mem_wmask = 8'h0F << addr_q[2:0];
          default: mem_wmask = 8'hFF;
        endcase
        state_nx = S_WB;
      end
      S_WB:    state_nx = S_FETCH;
      default: state_nx = S_HALT;
    endcase
  end

  // Load data alignment and extension.
  logic [63:0] ld_sh, ld_val;
  always_comb begin
    ld_sh = mem_rdata >> {addr_q[2:0], 3'b000};
    case (f3_q)
      3'd0:    ld_val = {{56{ld_sh[7]}},  ld_sh[7:0]};
      3'd1:    ld_val = {{48{ld_sh[15]}}, ld_sh[15:0]};
      3'd2:    ld_val = {{32{ld_sh[31]}}, ld_sh[31:0]};
      3'd4:    ld_val = {56'd0, ld_sh[7:0]};
      3'd5:    ld_val = {48'd0, ld_sh[15:0]};
      3'd6:    ld_val = {32'd0, ld_sh[31:0]};
      default: ld_val = ld_sh;
    endcase
  end

  // FSM state register.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= S_FETCH;
    else       state <= state_nx;
  end

  // Free-running cycle counter.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) cycle <= 64'd0;
    else       cycle <= cycle + 64'd1;
  end

  // Capture EXEC results; PC moves only in WB.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pc <= RESET_PC;
      rd_q <= 5'd0; wr_q <= 1'b0; ld_q <= 1'b0; st_q <= 1'b0; f3_q <= 3'd0;
      res_q <= 64'd0; npc_q <= 64'd0; addr_q <= 64'd0; sdata_q <= 64'd0;
    end else begin
      if (state == S_EXEC) begin
        rd_q <= rd; wr_q <= ex_wr; ld_q <= ex_ld; st_q <= ex_st; f3_q <= f3;
        res_q <= ex_res; npc_q <= ex_npc; addr_q <= ex_addr; sdata_q <= b;
      end
      if (state == S_WB) pc <= npc_q;
    end
  end

  // Architectural register file: written only in WB, x0 never written.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < 32; i++) regfile[i] <= 64'd0;
    end else if (state == S_WB && wr_q && rd_q != 5'd0) begin
      regfile[rd_q] <= ld_q ? ld_val : res_q;
    end
  end
endmodule

// File: tb/tb_rift_chip.sv
// Directed bench for rift_chip: short programs preloaded byte-wise into the
// SRAM, run to HALT, then registers and one data word are compared.
module tb_rift_chip;
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  rift_chip dut (.CLK(CLK), .RSTn(RSTn));

  localparam logic [2:0]  ST_FETCH = 3'd0;
  localparam logic [2:0]  ST_WB    = 3'd3;
  localparam logic [2:0]  ST_HALT  = 3'd4;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam logic [31:0] ECALL    = 32'h0000_0073;
  localparam logic [63:0] ONES     = 64'hFFFF_FFFF_FFFF_FFFF;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---- tiny assembler ----
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input int op);
    return {12'(imm), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd, input int op);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
    logic [11:0] m;
    m = 12'(imm);
    return {m[11:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [12:0] m;
    m = 13'(imm);
    return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] m;
    m = 21'(imm);
    return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'h6F};
  endfunction
  function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
    return enc_i(imm, rs1, 0, rd, 'h13);
  endfunction
  function automatic logic [31:0] auipc(input int rd, input int imm20);
    return {20'(imm20), 5'(rd), 7'h17};
  endfunction
  function automatic logic [31:0] load(input int rd, input int rs1, input int imm, input int f3);
    return enc_i(imm, rs1, f3, rd, 'h03);
  endfunction

  typedef struct {
    logic [7:0][31:0] p;
    logic [63:0]      data;   // preloaded at byte 0x400 (ram[128])
    logic [63:0]      mexp;   // ram[128] after the run
    int               ra;
    logic [63:0]      ea;
    int               rb;
    logic [63:0]      eb;
  } vec_t;

  function automatic vec_t mk(input logic [63:0] data, input logic [63:0] mexp,
                              input int ra, input logic [63:0] ea, input int rb, input logic [63:0] eb,
                              input logic [31:0] i0, input logic [31:0] i1 = 32'd0,
                              input logic [31:0] i2 = 32'd0, input logic [31:0] i3 = 32'd0,
                              input logic [31:0] i4 = 32'd0, input logic [31:0] i5 = 32'd0,
                              input logic [31:0] i6 = 32'd0, input logic [31:0] i7 = 32'd0);
    vec_t v;
    v.p[0] = i0; v.p[1] = i1; v.p[2] = i2; v.p[3] = i3;
    v.p[4] = i4; v.p[5] = i5; v.p[6] = i6; v.p[7] = i7;
    v.data = data; v.mexp = mexp; v.ra = ra; v.ea = ea; v.rb = rb; v.eb = eb;
    return v;
  endfunction

  task automatic write_byte(input int addr, input logic [7:0] val);
    dut.i_axi_full_slv_sram.i_sram.ram[addr / 8][8*(addr % 8) +: 8] = val;
  endtask

  // Hold reset, clear the used words, preload program and data byte by byte.
  task automatic load_image(input vec_t v);
    RSTn = 1'b0;
    @(negedge CLK);
    for (int w = 0; w < 8; w++) dut.i_axi_full_slv_sram.i_sram.ram[w] = 64'd0;
    dut.i_axi_full_slv_sram.i_sram.ram[128] = 64'd0;
    for (int j = 0; j < 8; j++)
      for (int k = 0; k < 4; k++) write_byte(4*j + k, v.p[j][8*k +: 8]);
    for (int k = 0; k < 8; k++) write_byte(32'h400 + k, v.data[8*k +: 8]);
    @(negedge CLK);
  endtask

  task automatic wait_halt(input int budget);
    int c;
    c = 0;
    while (dut.state != ST_HALT && c < budget) begin
      @(negedge CLK);
      c++;
    end
  endtask

  task automatic run_vec(input int n, input vec_t v);
    load_image(v);
    RSTn = 1'b1;
    wait_halt(2000);
    check($sformatf("v%0d halted", n), 64'(dut.state), 64'(ST_HALT));
    check($sformatf("v%0d x%0d", n, v.ra), dut.regfile[v.ra], v.ea);
    check($sformatf("v%0d x%0d", n, v.rb), dut.regfile[v.rb], v.eb);
    check($sformatf("v%0d ram[128]", n), dut.i_axi_full_slv_sram.i_sram.ram[128], v.mexp);
  endtask

  vec_t vecs[$];
  logic [63:0] pc_halt;
  localparam logic [63:0] D = 64'h8877_6655_4433_2211;

  initial begin
    // reset state before anything runs
    repeat (3) @(negedge CLK);
    check("reset pc", dut.pc, 64'h8000_0000);
    check("reset state", 64'(dut.state), 64'(ST_FETCH));
    check("reset x7", dut.regfile[7], 64'd0);
    check("reset cycle", dut.cycle, 64'd0);

    // addi x2,x0,5 / addi x1,x0,1 as one 64-bit word
    vecs.push_back(mk(0, 0, 2, 64'd5, 1, 64'd1, 32'h0050_0113, 32'h0010_0093, EBREAK));
    // sd then ld through auipc base
    vecs.push_back(mk(0, 64'd5, 3, 64'd5, 2, 64'd5,
      auipc(10, 0), addi(2, 0, 5), enc_s('h400, 2, 10, 3), load(3, 10, 'h400, 3), EBREAK));
    // lb / lbu of 0xFF
    vecs.push_back(mk(64'hFF, 64'hFF, 4, ONES, 5, 64'hFF,
      auipc(10, 0), load(4, 10, 'h400, 0), load(5, 10, 'h400, 4), EBREAK));
    // lh at byte 6, lwu at byte 4
    vecs.push_back(mk(D, D, 4, 64'hFFFF_FFFF_FFFF_8877, 5, 64'h0000_0000_8877_6655,
      auipc(10, 0), load(4, 10, 'h406, 1), load(5, 10, 'h404, 6), EBREAK));
    // ld, lw with sign bit set
    vecs.push_back(mk(D, D, 4, D, 5, 64'hFFFF_FFFF_8877_6655,
      auipc(10, 0), load(4, 10, 'h400, 3), load(5, 10, 'h404, 2), EBREAK));
    // sb into byte 3 leaves the rest alone
    vecs.push_back(mk(D, 64'h8877_6655_AB33_2211, 2, 64'hAB, 1, 64'hAB,
      auipc(10, 0), addi(1, 0, 'hAB), enc_s('h403, 1, 10, 0), load(2, 10, 'h403, 4), EBREAK));
    // addiw -1, srliw 1
    vecs.push_back(mk(0, 0, 4, ONES, 5, 64'h0000_0000_7FFF_FFFF,
      enc_i(-1, 0, 0, 4, 'h1B), enc_i(1, 4, 5, 5, 'h1B), EBREAK));
    // beq taken skips one instruction
    vecs.push_back(mk(0, 0, 6, 64'd0, 7, 64'd2,
      enc_b(8, 0, 0, 0), addi(6, 0, 1), addi(7, 0, 2), EBREAK));
    // bne not taken falls through
    vecs.push_back(mk(0, 0, 6, 64'd1, 7, 64'd2,
      enc_b(8, 0, 0, 1), addi(6, 0, 1), addi(7, 0, 2), EBREAK));
    // jal +12 links PC+4
    vecs.push_back(mk(0, 0, 1, 64'h8000_0004, 8, 64'd9,
      enc_j(12, 1), addi(8, 0, 1), addi(8, 0, 1), addi(8, 0, 9), EBREAK));
    // sub, srai
    vecs.push_back(mk(0, 0, 3, 64'hFFFF_FFFF_FFFF_FFF6, 4, 64'hFFFF_FFFF_FFFF_FFFB,
      addi(1, 0, -7), addi(2, 0, 3), enc_r('h20, 2, 1, 0, 3, 'h33), enc_i('h401, 3, 5, 4, 'h13), EBREAK));
    // sltu vs slt with -1
    vecs.push_back(mk(0, 0, 2, 64'd1, 3, 64'd0,
      addi(1, 0, -1), enc_r(0, 1, 0, 3, 2, 'h33), enc_r(0, 1, 0, 2, 3, 'h33), EBREAK));
    // addw sign-extends bit 31, sllw uses 5-bit shamt
    vecs.push_back(mk(0, 0, 2, 64'hFFFF_FFFF_8000_0000, 3, 64'd2,
      addi(1, 0, 1), enc_i(31, 1, 1, 1, 'h13), enc_r(0, 0, 1, 0, 2, 'h3B),
      addi(5, 0, 33), addi(6, 0, 1), enc_r(0, 5, 6, 1, 3, 'h3B), EBREAK));
    // sll uses 6-bit shamt, xori -1
    vecs.push_back(mk(0, 0, 3, 64'h0000_0002_0000_0000, 4, 64'hFFFF_FFFD_FFFF_FFFF,
      addi(6, 0, 1), addi(5, 0, 33), enc_r(0, 5, 6, 1, 3, 'h33), enc_i(-1, 3, 4, 4, 'h13), EBREAK));
    // x0 writes discarded
    vecs.push_back(mk(0, 0, 0, 64'd0, 1, 64'd3,
      addi(0, 0, 5), addi(1, 0, 3), enc_r(0, 0, 1, 0, 1, 'h33), EBREAK));
    // jalr clears bit 0 of the target
    vecs.push_back(mk(0, 0, 1, 64'h8000_000C, 13, 64'd7,
      auipc(10, 0), addi(11, 10, 17), enc_i(0, 11, 0, 1, 'h67), addi(12, 0, 1), addi(13, 0, 7), EBREAK));
    // cycle CSR advances 3 per non-memory instruction; other CSRs read 0
    vecs.push_back(mk(0, 0, 7, 64'd3, 8, 64'd0,
      enc_i('hC00, 0, 2, 5, 'h73), enc_i('hB00, 0, 6, 6, 'h73), enc_r('h20, 5, 6, 0, 7, 'h33),
      enc_i('h300, 0, 2, 8, 'h73), EBREAK));
    // loop: sum 10..1, ends on ECALL
    vecs.push_back(mk(0, 0, 2, 64'd55, 1, 64'd0,
      addi(1, 0, 10), addi(2, 0, 0), enc_r(0, 1, 2, 0, 2, 'h33), addi(1, 1, -1),
      enc_b(-8, 0, 1, 1), ECALL));
    // misaligned load halts before any write
    vecs.push_back(mk(D, D, 1, 64'd0, 2, 64'd0,
      auipc(10, 0), load(1, 10, 'h402, 2), addi(2, 0, 1), EBREAK));
    // misaligned branch target halts
    vecs.push_back(mk(0, 0, 3, 64'd4, 2, 64'd0,
      addi(3, 0, 4), enc_b(6, 0, 0, 0), addi(2, 0, 1), EBREAK));
    // out-of-window store ignored, load returns 0
    vecs.push_back(mk(0, 0, 1, 64'd5, 2, 64'd0,
      addi(1, 0, 5), addi(2, 0, 9), enc_s(0, 1, 0, 3), load(2, 0, 0, 3), EBREAK));
    // lui sign-extends, auipc adds PC
    vecs.push_back(mk(0, 0, 1, 64'hFFFF_FFFF_8000_0000, 2, 64'h0000_0000_8000_1004,
      {20'h80000, 5'd1, 7'h37}, auipc(2, 1), EBREAK));

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // HALT on all-zero word freezes PC and registers; reset restarts
    load_image(mk(0, 0, 0, 0, 0, 0, addi(1, 0, 1), 32'd0));
    RSTn = 1'b1;
    wait_halt(200);
    check("zero-op halted", 64'(dut.state), 64'(ST_HALT));
    check("zero-op pc", dut.pc, 64'h8000_0004);
    pc_halt = dut.pc;
    repeat (20) @(negedge CLK);
    check("halt pc frozen", dut.pc, pc_halt);
    check("halt x1 frozen", dut.regfile[1], 64'd1);
    check("halt stays", 64'(dut.state), 64'(ST_HALT));
    RSTn = 1'b0;
    #1;
    check("restart pc", dut.pc, 64'h8000_0000);
    check("restart state", 64'(dut.state), 64'(ST_FETCH));
    check("restart x1 cleared", dut.regfile[1], 64'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    wait_halt(200);
    check("rerun x1", dut.regfile[1], 64'd1);

    // reset asserted in WB aborts the pending register write
    load_image(mk(0, 0, 0, 0, 0, 0, addi(1, 0, 1), EBREAK));
    RSTn = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("abort in WB", 64'(dut.state), 64'(ST_WB));
    RSTn = 1'b0;
    #1;
    check("abort x1", dut.regfile[1], 64'd0);
    check("abort pc", dut.pc, 64'h8000_0000);
    check("abort cycle", dut.cycle, 64'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    wait_halt(200);
    check("after abort x1", dut.regfile[1], 64'd1);
    check("ebreak pc", dut.pc, 64'h8000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
